// File: rtl/rx_status_ctrl.sv
// rx_status_ctrl: admits RX frames, measures their byte length, collects the
// late good/bad verdict (or times it out) and queues one status word per
// frame in a small first-word-fall-through FIFO for the client.
module rx_status_ctrl #(
    parameter int DEPTH          = 4,
    parameter int STATUS_TIMEOUT = 16
) (
    input  logic        rxclk,
    input  logic        reset,
    input  logic        cfg_rx_en,
    input  logic        get_sfd,
    input  logic        receiving,
    input  logic [7:0]  rx_data_valid,
    input  logic        good_frame_get,
    input  logic        bad_frame_get,
    output logic        recv_enable,
    output logic        stat_valid,
    input  logic        stat_ready,
    output logic        stat_good,
    output logic        stat_timeout,
    output logic [15:0] stat_len,
    output logic [15:0] reject_cnt,
    output logic        busy
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = (STATUS_TIMEOUT > 1) ? $clog2(STATUS_TIMEOUT) : 1;

    typedef struct packed {
        logic        good;
        logic        timeout;
        logic [15:0] len;
    } stat_t;

    typedef enum logic [1:0] {IDLE, FRAME, WAIT} state_t;

    state_t          state, state_next;
    logic [15:0]     len, len_next, len_acc, len_cur;
    logic            seen, seen_next;
    logic [TW-1:0]   timer, timer_next;
    logic            push, pop, rej_inc, verdict;
    stat_t           push_word, head;
    stat_t           mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count, count_next;
    logic [16:0]     len_sum;

    function automatic logic [3:0] popcnt(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + {3'b0, v[i]};
        return n;
    endfunction

    // Saturating length including this cycle's lanes.
    always_comb begin
        len_sum = {1'b0, len} + {13'b0, popcnt(rx_data_valid)};
        len_acc = len_sum[16] ? 16'hFFFF : len_sum[15:0];
        len_cur = receiving ? len_acc : len;
    end

    assign verdict = good_frame_get | bad_frame_get;

    // Next-state, length/timer update and status push decision.
    always_comb begin
        state_next = state;
        len_next   = len;
        seen_next  = seen;
        timer_next = timer;
        push       = 1'b0;
        push_word  = '0;
        rej_inc    = 1'b0;
        case (state)
            IDLE: begin
                if (get_sfd) begin
                    if (recv_enable) begin
                        state_next = FRAME;
                        len_next   = '0;
                        seen_next  = 1'b0;
                    end else begin
                        rej_inc = 1'b1;
                    end
                end
            end
            FRAME: begin
                if (receiving) begin
                    len_next  = len_acc;
                    seen_next = 1'b1;
                end
                if (verdict) begin
                    push       = 1'b1;
                    push_word  = '{good: good_frame_get & ~bad_frame_get, timeout: 1'b0, len: len_cur};
                    state_next = IDLE;
                end else if (!receiving && seen) begin
                    state_next = WAIT;
                    timer_next = '0;
                end
            end
            WAIT: begin
                if (verdict) begin
                    push       = 1'b1;
                    push_word  = '{good: good_frame_get & ~bad_frame_get, timeout: 1'b0, len: len};
                    state_next = IDLE;
                end else if (timer == TW'(STATUS_TIMEOUT - 1)) begin
                    push       = 1'b1;
                    push_word  = '{good: 1'b0, timeout: 1'b1, len: len};
                    state_next = IDLE;
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign stat_valid = (count != '0);
    assign pop        = stat_valid & stat_ready;
    assign count_next = count + CW'(push) - CW'(pop);

    // Control state, FIFO pointers, reject counter and registered admit gate.
    always_ff @(posedge rxclk) begin
        if (reset) begin
            state       <= IDLE;
            len         <= '0;
            seen        <= 1'b0;
            timer       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            reject_cnt  <= '0;
            recv_enable <= 1'b0;
        end else begin
            state  <= state_next;
            len    <= len_next;
            seen   <= seen_next;
            timer  <= timer_next;
            count  <= count_next;
            if (push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            if (pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            if (rej_inc && reject_cnt != 16'hFFFF) reject_cnt <= reject_cnt + 16'd1;
            // The in-flight frame's slot is reserved by only admitting in IDLE with room.
            recv_enable <= cfg_rx_en & (state_next == IDLE) & (count_next < CW'(DEPTH));
        end
    end

    // Status storage; contents are only observed through the valid-gated head.
    always_ff @(posedge rxclk) begin
        if (push) mem[wr_ptr] <= push_word;
    end

    assign head         = mem[rd_ptr];
    assign stat_good    = stat_valid & head.good;
    assign stat_timeout = stat_valid & head.timeout;
    assign stat_len     = stat_valid ? head.len : 16'h0;
    assign busy         = (state != IDLE);
endmodule
